// File: rtl/io_rail_seq_pkg.sv
// Shared state encoding and parameter helpers for the IO rail switch sequencer.
package io_rail_seq_pkg;

  typedef enum logic [2:0] {
    OFF,
    UP_WAIT,
    UP_GAP,
    ON,
    DN_WAIT,
    DN_GAP,
    FAULT
  } seq_state_t;

  function automatic int idx_width(input int num_rails);
    return (num_rails <= 1) ? 1 : $clog2(num_rails);
  endfunction

  // Sized so the counter can hold the larger of the gap and timeout limits.
  function automatic int cnt_width(input int stagger, input int timeout);
    return $clog2(((stagger > timeout) ? stagger : timeout) + 1);
  endfunction

  function automatic bit params_legal(input int num_rails, input int stagger,
                                      input int timeout, input int sync_stages);
    return (num_rails >= 1) && (num_rails <= 16) && (stagger >= 1) &&
           (sync_stages >= 2) && (timeout > sync_stages);
  endfunction

endpackage

// File: rtl/io_ack_sync.sv
// Multi-bit flop-chain synchroniser for the asynchronous rail-good acknowledges.
module io_ack_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/io_rail_switch_seq.sv
// Staggered power-up / power-down sequencer for switchable IO supply rails,
// with per-step acknowledge timeout and a latched fault that shuts all rails off.
module io_rail_switch_seq
  import io_rail_seq_pkg::*;
#(
  parameter int NUM_RAILS   = 4,
  parameter int STAGGER     = 8,
  parameter int TIMEOUT     = 64,
  parameter int SYNC_STAGES = 2,
  localparam int IDXW       = idx_width(NUM_RAILS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_on_i,
  input  logic [NUM_RAILS-1:0] ack_i,
  input  logic                 clr_fault_i,
  output logic [NUM_RAILS-1:0] en_o,
  output logic                 done_on_o,
  output logic                 done_off_o,
  output logic                 busy_o,
  output logic                 fault_o,
  output logic [IDXW-1:0]      fault_idx_o
);

  localparam int CW = cnt_width(STAGGER, TIMEOUT);
  localparam logic [CW-1:0]   TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   GAP_LAST = CW'(STAGGER - 1);
  localparam logic [CW-1:0]   CNT_MAX  = '1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_RAILS - 1);

  if (!params_legal(NUM_RAILS, STAGGER, TIMEOUT, SYNC_STAGES)) begin : g_bad_params
    $error("io_rail_switch_seq: illegal parameter combination");
  end

  seq_state_t          state;
  logic [IDXW-1:0]     idx;
  logic [CW-1:0]       cnt;
  logic [NUM_RAILS-1:0] ack_s;
  logic [CW-1:0]       cnt_inc;
  logic [IDXW-1:0]     idx_up;
  logic [IDXW-1:0]     idx_dn;

  io_ack_sync #(
    .WIDTH  (NUM_RAILS),
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ack_i),
    .q     (ack_s)
  );

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign idx_up  = idx + 1'b1;
  assign idx_dn  = idx - 1'b1;

  // req_on_i is only looked at in OFF, ON and at gap ends, so a request
  // change during a WAIT never disturbs the enable currently being acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= OFF;
      idx         <= '0;
      cnt         <= '0;
      en_o        <= '0;
      done_on_o   <= 1'b0;
      done_off_o  <= 1'b1;
      busy_o      <= 1'b0;
      fault_o     <= 1'b0;
      fault_idx_o <= '0;
    end else begin
      case (state)
        OFF: begin
          if (req_on_i) begin
            idx        <= '0;
            en_o[0]    <= 1'b1;
            cnt        <= '0;
            busy_o     <= 1'b1;
            done_off_o <= 1'b0;
            state      <= UP_WAIT;
          end
        end

        UP_WAIT: begin
          if (ack_s[idx]) begin
            cnt   <= '0;
            state <= UP_GAP;
          end else if (cnt == TO_LAST) begin
            en_o        <= '0;
            fault_o     <= 1'b1;
            fault_idx_o <= idx;
            busy_o      <= 1'b0;
            cnt         <= '0;
            state       <= FAULT;
          end else begin
            cnt <= cnt_inc;
          end
        end

        UP_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (!req_on_i) begin
              en_o[idx] <= 1'b0;
              state     <= DN_WAIT;
            end else if (idx == IDX_LAST) begin
              busy_o    <= 1'b0;
              done_on_o <= 1'b1;
              state     <= ON;
            end else begin
              idx          <= idx_up;
              en_o[idx_up] <= 1'b1;
              state        <= UP_WAIT;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end

        // Loss of ack_s here is a brown-out indication only; state is held.
        ON: begin
          if (!req_on_i) begin
            idx            <= IDX_LAST;
            en_o[IDX_LAST] <= 1'b0;
            cnt            <= '0;
            busy_o         <= 1'b1;
            done_on_o      <= 1'b0;
            state          <= DN_WAIT;
          end
        end

        DN_WAIT: begin
          if (!ack_s[idx]) begin
            cnt   <= '0;
            state <= DN_GAP;
          end else if (cnt == TO_LAST) begin
            en_o        <= '0;
            fault_o     <= 1'b1;
            fault_idx_o <= idx;
            busy_o      <= 1'b0;
            cnt         <= '0;
            state       <= FAULT;
          end else begin
            cnt <= cnt_inc;
          end
        end

        DN_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (req_on_i) begin
              en_o[idx] <= 1'b1;
              state     <= UP_WAIT;
            end else if (idx == '0) begin
              busy_o     <= 1'b0;
              done_off_o <= 1'b1;
              state      <= OFF;
            end else begin
              idx          <= idx_dn;
              en_o[idx_dn] <= 1'b0;
              state        <= DN_WAIT;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end

        FAULT: begin
          if (clr_fault_i && !req_on_i) begin
            fault_o    <= 1'b0;
            done_off_o <= 1'b1;
            idx        <= '0;
            cnt        <= '0;
            state      <= OFF;
          end
        end

        default: begin
          en_o       <= '0;
          idx        <= '0;
          cnt        <= '0;
          busy_o     <= 1'b0;
          done_on_o  <= 1'b0;
          done_off_o <= 1'b1;
          fault_o    <= 1'b0;
          state      <= OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_rail_switch_seq.sv
// Directed bench for io_rail_switch_seq with a delayed-acknowledge switch-cell model.
module tb_io_rail_switch_seq;

  localparam int N = 4;
  localparam int BUDGET = 200;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_on_i;
  logic         clr_fault_i;
  logic [N-1:0] ack_i;
  logic [N-1:0] en_o;
  logic         done_on_o;
  logic         done_off_o;
  logic         busy_o;
  logic         fault_o;
  logic [1:0]   fault_idx_o;

  logic [N-1:0] hist [4] = '{default: '0};
  logic [N-1:0] stuck_low = '0;
  logic [N-1:0] en_seen = '0;
  int total = 0;
  int bad = 0;
  int cyc;
  int acc;

  io_rail_switch_seq #(
    .NUM_RAILS   (4),
    .STAGGER     (8),
    .TIMEOUT     (64),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_on_i    (req_on_i),
    .ack_i       (ack_i),
    .clr_fault_i (clr_fault_i),
    .en_o        (en_o),
    .done_on_o   (done_on_o),
    .done_off_o  (done_off_o),
    .busy_o      (busy_o),
    .fault_o     (fault_o),
    .fault_idx_o (fault_idx_o)
  );

  always #5 clk = ~clk;

  // Switch-cell model: rail-good follows its enable four clock edges later.
  always @(posedge clk) begin
    hist[0] <= en_o;
    hist[1] <= hist[0];
    hist[2] <= hist[1];
    hist[3] <= hist[2];
  end
  assign ack_i = hist[3] & ~stuck_low;

  task automatic apply_stimulus(input logic req, input logic clr);
    req_on_i    = req;
    clr_fault_i = clr;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_en(input logic [N-1:0] target, output int cycles);
    cycles = 0;
    while (en_o !== target && cycles < BUDGET) begin
      @(negedge clk);
      cycles++;
      en_seen = en_seen | en_o;
    end
  endtask

  // which: 0 = done_on_o, 1 = done_off_o, 2 = fault_o
  task automatic wait_flag(input int which, output int cycles);
    logic hit;
    cycles = 0;
    hit = 1'b0;
    while (!hit && cycles < BUDGET) begin
      case (which)
        0:       hit = (done_on_o === 1'b1);
        1:       hit = (done_off_o === 1'b1);
        default: hit = (fault_o === 1'b1);
      endcase
      if (!hit) begin
        @(negedge clk);
        cycles++;
        en_seen = en_seen | en_o;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    apply_stimulus(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] reset values");
    check_output("rst_en", en_o, 4'b0000);
    check_output("rst_done_off", done_off_o, 1'b1);
    check_output("rst_done_on", done_on_o, 1'b0);
    check_output("rst_busy", busy_o, 1'b0);
    check_output("rst_fault", fault_o, 1'b0);
    check_output("rst_fault_idx", fault_idx_o, 2'd0);

    $display("[TB] power-up");
    apply_stimulus(1'b1, 1'b0);
    wait_en(4'b0001, cyc); acc = cyc;
    check_output("up_en0_lat", cyc, 1);
    wait_en(4'b0011, cyc); acc += cyc;
    check_output("up_en1_gap", cyc, 15);
    check_output("up_busy", busy_o, 1'b1);
    check_output("up_done_off", done_off_o, 1'b0);
    wait_en(4'b0111, cyc); acc += cyc;
    check_output("up_en2_gap", cyc, 15);
    wait_en(4'b1111, cyc); acc += cyc;
    check_output("up_en3_gap", cyc, 15);
    wait_flag(0, cyc); acc += cyc;
    check_output("up_done_on_lat", acc, 61);
    check_output("on_busy", busy_o, 1'b0);
    check_output("on_done_off", done_off_o, 1'b0);

    $display("[TB] power-down");
    apply_stimulus(1'b0, 1'b0);
    wait_en(4'b0111, cyc);
    check_output("dn_en3_lat", cyc, 1);
    check_output("dn_done_on", done_on_o, 1'b0);
    wait_en(4'b0011, cyc);
    check_output("dn_en2_gap", cyc, 15);
    wait_en(4'b0001, cyc);
    check_output("dn_en1_gap", cyc, 15);
    wait_en(4'b0000, cyc);
    check_output("dn_en0_gap", cyc, 15);
    wait_flag(1, cyc);
    check_output("dn_done_off_lat", cyc, 15);
    check_output("off_busy", busy_o, 1'b0);

    $display("[TB] timeout on rail 2");
    stuck_low = 4'b0100;
    apply_stimulus(1'b1, 1'b0);
    wait_en(4'b0001, cyc);
    wait_en(4'b0011, cyc);
    wait_en(4'b0111, cyc);
    check_output("to_en2_gap", cyc, 15);
    wait_flag(2, cyc);
    check_output("to_fault_lat", cyc, 64);
    check_output("to_fault_idx", fault_idx_o, 2'd2);
    check_output("to_en_off", en_o, 4'b0000);
    check_output("to_done_on", done_on_o, 1'b0);
    check_output("to_done_off", done_off_o, 1'b0);
    check_output("to_busy", busy_o, 1'b0);
    apply_stimulus(1'b1, 1'b1);
    @(negedge clk);
    apply_stimulus(1'b1, 1'b0);
    @(negedge clk);
    check_output("clr_ignored_fault", fault_o, 1'b1);
    check_output("clr_ignored_en", en_o, 4'b0000);
    apply_stimulus(1'b0, 1'b1);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0);
    check_output("clr_fault", fault_o, 1'b0);
    check_output("clr_done_off", done_off_o, 1'b1);
    check_output("clr_idx_held", fault_idx_o, 2'd2);
    stuck_low = 4'b0000;
    repeat (8) @(negedge clk);

    $display("[TB] reversal during rail 1 wait");
    apply_stimulus(1'b1, 1'b0);
    wait_en(4'b0001, cyc);
    wait_en(4'b0011, cyc);
    en_seen = '0;
    apply_stimulus(1'b0, 1'b0);
    wait_en(4'b0001, cyc);
    check_output("rev_en1_fall", cyc, 15);
    wait_en(4'b0000, cyc);
    check_output("rev_en0_fall", cyc, 15);
    wait_flag(1, cyc);
    check_output("rev_done_off", cyc, 15);
    check_output("rev_no_en2", en_seen[2], 1'b0);
    repeat (8) @(negedge clk);

    $display("[TB] async reset mid-sequence");
    apply_stimulus(1'b1, 1'b0);
    wait_en(4'b0001, cyc);
    wait_en(4'b0011, cyc);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("arst_en", en_o, 4'b0000);
    check_output("arst_done_off", done_off_o, 1'b1);
    check_output("arst_done_on", done_on_o, 1'b0);
    check_output("arst_busy", busy_o, 1'b0);
    check_output("arst_fault_idx", fault_idx_o, 2'd0);
    apply_stimulus(1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    apply_stimulus(1'b1, 1'b0);
    wait_en(4'b0001, cyc);
    check_output("restart_en0_lat", cyc, 1);
    wait_en(4'b0011, cyc);
    check_output("restart_en1_gap", cyc, 15);
    wait_en(4'b0111, cyc);
    wait_en(4'b1111, cyc);
    wait_flag(0, cyc);
    check_output("restart_done_on", cyc, 15);

    $display("[TB] brown-out while on");
    stuck_low = 4'b0010;
    repeat (10) @(negedge clk);
    check_output("bo_done_on", done_on_o, 1'b1);
    check_output("bo_en", en_o, 4'b1111);
    check_output("bo_busy", busy_o, 1'b0);
    stuck_low = 4'b0000;
    repeat (8) @(negedge clk);

    $display("[TB] request glitch during down wait");
    apply_stimulus(1'b0, 1'b0);
    wait_en(4'b0111, cyc);
    check_output("gl_en3_lat", cyc, 1);
    @(negedge clk);
    apply_stimulus(1'b1, 1'b0);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0);
    wait_en(4'b0011, cyc);
    check_output("gl_en2_gap", cyc + 2, 15);
    apply_stimulus(1'b1, 1'b0);
    wait_en(4'b0111, cyc);
    check_output("gl_rev_en2", cyc, 15);
    wait_en(4'b1111, cyc);
    check_output("gl_rev_en3", cyc, 15);
    wait_flag(0, cyc);
    check_output("gl_done_on", cyc, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
